cmd_parser: RTL

- Sits directly downstream of the receive FIFO, which the FT245-style USB FIFO interface fills with host bytes.
- Pops bytes from that FIFO and decodes fixed-length command frames into per-channel phase and PWM-enable registers.
- Shadows all writes and commits them atomically to the outputs consumed by phase calibration / PWM generation.
- Recovers from truncated frames via an inter-byte timeout.

---
 rtl/cmd_pkg.sv | 24 ++
 rtl/cmd_shadow_regs.sv | 59 +++++
 rtl/cmd_parser.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared opcodes, parser state encoding and helpers for the host command parser.
package cmd_pkg;

    localparam logic [7:0] OP_SET_PHASE = 8'h01;
    localparam logic [7:0] OP_SET_EN    = 8'h02;
    localparam logic [7:0] OP_COMMIT    = 8'h03;
    localparam logic [7:0] OP_CLEAR     = 8'h04;

    typedef enum logic [1:0] {
        S_CMD = 2'd0,
        S_CH  = 2'd1,
        S_VAL = 2'd2
    } parser_state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return 8'hFF;
        end else begin
            return v + 8'd1;
        end
    endfunction

endpackage

// File: rtl/cmd_shadow_regs.sv
// Shadow and active phase/enable banks; shadow writes and clears are staged,
// then a commit copies the whole shadow bank to the active outputs at once.
module cmd_shadow_regs #(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 8,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    ch,
    input  logic [PHASE_W-1:0] value,
    input  logic               is_en,
    input  logic               do_commit,
    input  logic               do_clear,
    output logic [PHASE_W-1:0] phase [N_CH],
    output logic [N_CH-1:0]    pwm_en,
    output logic               commit
);

    logic [PHASE_W-1:0] shadow_phase_r [N_CH];
    logic [N_CH-1:0]    shadow_en_r;
    logic [PHASE_W-1:0] phase_r [N_CH];
    logic [N_CH-1:0]    pwm_en_r;
    logic               commit_r;

    // Shadow bank update, atomic commit to the active bank and commit strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_phase_r <= '{default: '0};
            shadow_en_r    <= '0;
            phase_r        <= '{default: '0};
            pwm_en_r       <= '0;
            commit_r       <= 1'b0;
        end else begin
            commit_r <= do_commit;
            if (do_clear) begin
                shadow_phase_r <= '{default: '0};
                shadow_en_r    <= '0;
            end else if (wr_en) begin
                if (is_en) begin
                    shadow_en_r[ch] <= value[0];
                end else begin
                    shadow_phase_r[ch] <= value;
                end
            end
            // Frames are serial, so a commit never coincides with a shadow write.
            if (do_commit) begin
                phase_r  <= shadow_phase_r;
                pwm_en_r <= shadow_en_r;
            end
        end
    end

    assign phase  = phase_r;
    assign pwm_en = pwm_en_r;
    assign commit = commit_r;

endmodule

// File: rtl/cmd_parser.sv
// Pops host bytes from the receive FIFO, decodes fixed-length command frames
// and drives the shadow/active register banks; abandons stalled frames.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PHASE_W = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rxfifo_empty,
    output logic               rxfifo_rdreq,
    input  logic [7:0]         rxfifo_data,
    output logic [PHASE_W-1:0] phase [N_CH],
    output logic [N_CH-1:0]    pwm_en,
    output logic               commit,
    output logic [7:0]         err_count,
    output logic               busy
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    parser_state_t    state_r, state_next_s;
    logic [7:0]       op_r, op_next_s;
    logic [7:0]       ch_r, ch_next_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [7:0]       err_count_r;
    logic             byte_valid_r;
    logic             busy_r;
    logic             tmo_hit_s;
    logic             ch_ok_s;
    logic             is_en_s;
    logic             wr_s;
    logic             commit_s;
    logic             clear_s;
    logic             err_inc_s;

    // No back-pressure: pop whenever data is available.
    assign rxfifo_rdreq = !rxfifo_empty && !reset;
    assign tmo_hit_s    = (tmo_cnt_r == TMO_LAST);
    assign ch_ok_s      = ({1'b0, ch_r} < 9'(N_CH));
    assign is_en_s      = (op_r == OP_SET_EN);

    // Frame decoder: next state and one-cycle action strobes.
    always_comb begin
        state_next_s = state_r;
        op_next_s    = op_r;
        ch_next_s    = ch_r;
        wr_s         = 1'b0;
        commit_s     = 1'b0;
        clear_s      = 1'b0;
        err_inc_s    = 1'b0;
        case (state_r)
            S_CMD: begin
                if (byte_valid_r) begin
                    case (rxfifo_data)
                        OP_SET_PHASE, OP_SET_EN: begin
                            op_next_s    = rxfifo_data;
                            state_next_s = S_CH;
                        end
                        OP_COMMIT: commit_s  = 1'b1;
                        OP_CLEAR:  clear_s   = 1'b1;
                        default:   err_inc_s = 1'b1;
                    endcase
                end else begin
                    state_next_s = S_CMD;
                end
            end
            S_CH: begin
                if (byte_valid_r) begin
                    ch_next_s    = rxfifo_data;
                    state_next_s = S_VAL;
                end else if (tmo_hit_s) begin
                    err_inc_s    = 1'b1;
                    state_next_s = S_CMD;
                end else begin
                    state_next_s = S_CH;
                end
            end
            S_VAL: begin
                if (byte_valid_r) begin
                    if (ch_ok_s) begin
                        wr_s = 1'b1;
                    end else begin
                        err_inc_s = 1'b1;
                    end
                    state_next_s = S_CMD;
                end else if (tmo_hit_s) begin
                    err_inc_s    = 1'b1;
                    state_next_s = S_CMD;
                end else begin
                    state_next_s = S_VAL;
                end
            end
            default: state_next_s = S_CMD;
        endcase
    end

    // Parser state, inter-byte timeout counter and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= S_CMD;
            op_r         <= 8'h00;
            ch_r         <= 8'h00;
            tmo_cnt_r    <= '0;
            err_count_r  <= 8'h00;
            byte_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            op_r         <= op_next_s;
            ch_r         <= ch_next_s;
            byte_valid_r <= rxfifo_rdreq;
            busy_r       <= (state_next_s != S_CMD);
            if (byte_valid_r || (state_r == S_CMD) || tmo_hit_s) begin
                tmo_cnt_r <= '0;
            end else begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end
            if (err_inc_s) begin
                err_count_r <= sat_inc(err_count_r);
            end else begin
                err_count_r <= err_count_r;
            end
        end
    end

    cmd_shadow_regs #(
        .N_CH    (N_CH),
        .PHASE_W (PHASE_W),
        .CH_W    (CH_W)
    ) u_shadow (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_s),
        .ch        (ch_r[CH_W-1:0]),
        .value     (rxfifo_data[PHASE_W-1:0]),
        .is_en     (is_en_s),
        .do_commit (commit_s),
        .do_clear  (clear_s),
        .phase     (phase),
        .pwm_en    (pwm_en),
        .commit    (commit)
    );

    assign err_count = err_count_r;
    assign busy      = busy_r;

endmodule
